// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result channels of the nibble-serial adder.
// The master side is the producer/consumer; the slave side is the adder.
interface nibble_serial_adder_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         busy;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple-carry slice reused over NIBBLES cycles,
// least-significant nibble first, with the carry held in a register between cycles.

module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [4:0] c;

  assign c[0] = Cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign Cout = c[4];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice add per cycle, nibble idx
// DONE  | result held, out_valid high until out_ready
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg, s_reg;
  logic           carry, cout_reg;
  logic [IW-1:0]  idx;
  logic [3:0]     a_nib, b_nib, slice_s;
  logic           slice_cout;
  logic           last;

  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  ripple_carry_adder u_slice (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output handshake in DONE wins; a waiting operand is taken in the next IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            carry    <= bus.Cin;
            idx      <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) s_reg[4*i +: 4] <= slice_s;
          end
          carry <= slice_cout;
          if (last) cout_reg <= slice_cout;
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.S         = s_reg;
  assign bus.Cout      = cout_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed checks of the nibble-serial adder at NIBBLES=4 and 1, plus a
// randomised handshake run at NIBBLES=8 against a golden sum.
module tb_nibble_serial_adder;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();
  nibble_serial_adder_if #(.NIBBLES(8)) bus8 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  nibble_serial_adder #(.NIBBLES(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation on the 4-nibble instance, entered from IDLE.
  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic [16:0] exp);
    int cyc;
    int nb;
    bus4.A = a; bus4.B = b; bus4.Cin = c; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    cyc = 0;
    nb  = 0;
    while (!bus4.out_valid && cyc < 20) begin
      if (bus4.busy) nb++;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd4);
    chk({tag, "_sum"}, 64'({bus4.Cout, bus4.S}), 64'(exp));
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    chk({tag, "_release"}, 64'({bus4.out_valid, bus4.in_ready, bus4.busy}), 64'b010);
    chk({tag, "_hold_idle"}, 64'({bus4.Cout, bus4.S}), 64'(exp));
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] exp8;
    logic        ov_seen;
    int          sent;
    int          got;
    int          cyc;

    bus4.in_valid = 0; bus4.A = '0; bus4.B = '0; bus4.Cin = 0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.A = '0; bus1.B = '0; bus1.Cin = 0; bus1.out_ready = 0;
    bus8.in_valid = 0; bus8.A = '0; bus8.B = '0; bus8.Cin = 0; bus8.out_ready = 0;
    rst = 1'b1;
    #1;
    chk("reset_flags", 64'({bus4.in_ready, bus4.out_valid, bus4.busy}), 64'b100);
    chk("reset_result", 64'({bus4.Cout, bus4.S}), 64'd0);
    tick();
    rst = 1'b0;

    op4("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 17'h0_2233);
    op4("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    op4("add_0_0_cin", 16'h0000, 16'h0000, 1'b1, 17'h0_0001);

    // Backpressure in DONE with a competing operand request
    bus4.A = 16'h1111; bus4.B = 16'h2222; bus4.Cin = 0; bus4.in_valid = 1;
    tick();
    bus4.in_valid = 0;
    repeat (4) tick();
    chk("bp_done_reached", 64'(bus4.out_valid), 64'd1);
    bus4.A = 16'hAAAA; bus4.B = 16'h5555; bus4.Cin = 1; bus4.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_flags", 64'({bus4.out_valid, bus4.in_ready, bus4.busy}), 64'b100);
      chk("bp_hold_sum", 64'({bus4.Cout, bus4.S}), 64'h0_3333);
    end
    bus4.out_ready = 1;
    tick();
    bus4.out_ready = 0;
    chk("bp_not_captured", 64'({bus4.out_valid, bus4.in_ready, bus4.busy}), 64'b010);
    chk("bp_old_sum_kept", 64'({bus4.Cout, bus4.S}), 64'h0_3333);
    tick();
    bus4.in_valid = 0;
    chk("bp_captured_in_idle", 64'(bus4.busy), 64'd1);
    repeat (4) tick();
    chk("bp_second_valid", 64'(bus4.out_valid), 64'd1);
    chk("bp_second_sum", 64'({bus4.Cout, bus4.S}), 64'h1_0000);
    bus4.out_ready = 1;
    tick();
    bus4.out_ready = 0;

    // Reset two cycles into RUN
    bus4.A = 16'hFFFF; bus4.B = 16'hFFFF; bus4.Cin = 0; bus4.in_valid = 1;
    tick();
    bus4.in_valid = 0;
    tick();
    tick();
    chk("mid_busy_before_rst", 64'(bus4.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flags", 64'({bus4.in_ready, bus4.out_valid, bus4.busy}), 64'b100);
    chk("mid_rst_result", 64'({bus4.Cout, bus4.S}), 64'd0);
    tick();
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus4.out_valid) ov_seen = 1'b1;
    end
    chk("mid_rst_no_valid", 64'(ov_seen), 64'd0);
    op4("after_rst_1_1", 16'h0001, 16'h0001, 1'b0, 17'h0_0002);

    // Single-nibble build
    bus1.A = 4'h6; bus1.B = 4'h1; bus1.Cin = 1; bus1.in_valid = 1;
    tick();
    bus1.in_valid = 0;
    chk("n1_run", 64'({bus1.busy, bus1.out_valid}), 64'b10);
    tick();
    chk("n1_done", 64'({bus1.busy, bus1.out_valid}), 64'b01);
    chk("n1_sum", 64'({bus1.Cout, bus1.S}), 64'h08);
    bus1.out_ready = 1;
    tick();
    bus1.out_ready = 0;
    chk("n1_idle", 64'(bus1.in_ready), 64'd1);

    // Eight-nibble random traffic with random handshakes
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1000 && cyc < 60000) begin
      bus8.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      bus8.A         = $urandom;
      bus8.B         = $urandom;
      bus8.Cin       = 1'($urandom_range(0, 1));
      bus8.out_ready = ($urandom_range(0, 2) != 0);
      if (bus8.in_valid && bus8.in_ready) begin
        q.push_back({1'b0, bus8.A} + {1'b0, bus8.B} + 33'(bus8.Cin));
        sent++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (q.size() > 0) begin
          exp8 = q.pop_front();
          chk("n8_random_sum", 64'({bus8.Cout, bus8.S}), 64'(exp8));
        end else begin
          chk("n8_unexpected_result", 64'(q.size()), 64'd1);
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus8.in_valid  = 0;
    bus8.out_ready = 0;
    chk("n8_result_count", 64'(got), 64'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
